// File: rtl/lsu_dmem_pkg.sv
// Shared types and constants for the lsu_dmem load/store unit.
// Encodings: RV32I funct3 access codes, FSM states, byte-enable patterns.
package lsu_dmem_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_e;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Illegal funct3 codes (011, 110, 111) fall through to a word access.
  function automatic lsu_size_e lsu_size(input logic [2:0] f3);
    case (f3)
      LSU_B, LSU_BU: return SZ_B;
      LSU_H, LSU_HU: return SZ_H;
      LSU_W:         return SZ_W;
      default:       return SZ_W;
    endcase
  endfunction

  function automatic logic lsu_unsigned(input logic [2:0] f3);
    return (f3 == LSU_BU) || (f3 == LSU_HU);
  endfunction

  function automatic logic lsu_misaligned(input lsu_size_e sz, input logic [1:0] lane);
    case (sz)
      SZ_H:    return lane[0];
      SZ_W:    return lane != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] lsu_force_align(input lsu_size_e sz, input logic [1:0] lane);
    case (sz)
      SZ_H:    return {lane[1], 1'b0};
      SZ_W:    return 2'b00;
      default: return lane;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for lsu_dmem: store replication and byte enables,
// load lane select with sign/zero extension.
module lsu_align
  import lsu_dmem_pkg::*;
(
  input  lsu_size_e   st_size,
  input  logic [1:0]  st_lane,
  input  logic [31:0] st_data,
  input  logic        st_we,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  lsu_size_e   ld_size,
  input  logic        ld_unsigned,
  input  logic [1:0]  ld_lane,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Loads always request the full word; only stores narrow the enables.
  always_comb begin
    st_be    = BE_WORD;
    st_wdata = st_data;
    if (st_we) begin
      case (st_size)
        SZ_B: begin
          st_be    = BE_BYTE << st_lane;
          st_wdata = {4{st_data[7:0]}};
        end
        SZ_H: begin
          st_be    = BE_HALF << {st_lane[1], 1'b0};
          st_wdata = {2{st_data[15:0]}};
        end
        default: begin
          st_be    = BE_WORD;
          st_wdata = st_data;
        end
      endcase
    end
  end

  always_comb begin
    ld_byte = ld_rdata[7:0];
    case (ld_lane)
      2'd0:    ld_byte = ld_rdata[7:0];
      2'd1:    ld_byte = ld_rdata[15:8];
      2'd2:    ld_byte = ld_rdata[23:16];
      default: ld_byte = ld_rdata[31:24];
    endcase
    ld_half = ld_lane[1] ? ld_rdata[31:16] : ld_rdata[15:0];

    case (ld_size)
      SZ_B:    ld_data = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
      SZ_H:    ld_data = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_dmem.sv
// Load/store unit: one req/ack data-memory transaction per load/store, stalling the core.
// Build option LSU_MISALIGN_TRAP_EN traps misaligned accesses instead of force-aligning them.
module lsu_dmem
  import lsu_dmem_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic              stall,
  output logic [31:0]       load_data,
  output logic              misaligned,
  output logic              bus_err,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  lsu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              dmem_req_q, dmem_req_d;
  logic              dmem_we_q, dmem_we_d;
  logic [ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
  logic [31:0]       dmem_wdata_q, dmem_wdata_d;
  logic [3:0]        dmem_be_q, dmem_be_d;
  logic [31:0]       load_data_q, load_data_d;
  logic              bus_err_q, bus_err_d;
  lsu_size_e         ld_size_q, ld_size_d;
  logic              ld_unsigned_q, ld_unsigned_d;
  logic [1:0]        lane_q, lane_d;

  logic              start;
  lsu_size_e         req_size;
  logic [1:0]        req_lane;
  logic [3:0]        al_be;
  logic [31:0]       al_wdata;
  logic [31:0]       al_ld_data;

  assign start    = mem_read | mem_write;
  assign req_size = lsu_size(funct3);

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned_q, misaligned_d;
  logic req_misaligned;
  assign req_misaligned = lsu_misaligned(req_size, addr[1:0]);
  assign req_lane       = addr[1:0];
  assign misaligned     = misaligned_q;
`else
  assign req_lane   = lsu_force_align(req_size, addr[1:0]);
  assign misaligned = 1'b0;
`endif

  // Store lanes come straight from the inputs at latch time; load lanes from the latched request.
  lsu_align u_align (
    .st_size     (req_size),
    .st_lane     (req_lane),
    .st_data     (store_data),
    .st_we       (mem_write),
    .st_be       (al_be),
    .st_wdata    (al_wdata),
    .ld_size     (ld_size_q),
    .ld_unsigned (ld_unsigned_q),
    .ld_lane     (lane_q),
    .ld_rdata    (dmem_rdata),
    .ld_data     (al_ld_data)
  );

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    dmem_req_d    = dmem_req_q;
    dmem_we_d     = dmem_we_q;
    dmem_addr_d   = dmem_addr_q;
    dmem_wdata_d  = dmem_wdata_q;
    dmem_be_d     = dmem_be_q;
    load_data_d   = load_data_q;
    bus_err_d     = bus_err_q;
    ld_size_d     = ld_size_q;
    ld_unsigned_d = ld_unsigned_q;
    lane_d        = lane_q;
`ifdef LSU_MISALIGN_TRAP_EN
    misaligned_d  = misaligned_q;
`endif

    case (state_q)
      LSU_IDLE: begin
        if (start) begin
          state_d       = LSU_REQ;
          wait_cnt_d    = '0;
          dmem_req_d    = 1'b1;
          dmem_we_d     = mem_write;
          dmem_addr_d   = {addr[ADDR_W-1:2], 2'b00};
          dmem_wdata_d  = al_wdata;
          dmem_be_d     = al_be;
          load_data_d   = '0;
          ld_size_d     = req_size;
          ld_unsigned_d = lsu_unsigned(funct3);
          lane_d        = req_lane;
`ifdef LSU_MISALIGN_TRAP_EN
          if (req_misaligned) begin
            state_d      = LSU_DONE;
            dmem_req_d   = 1'b0;
            dmem_we_d    = 1'b0;
            misaligned_d = 1'b1;
          end
`endif
        end
      end
      LSU_REQ: begin
        // An ack in the final watchdog cycle still completes the access normally.
        if (dmem_ack) begin
          state_d    = LSU_DONE;
          dmem_req_d = 1'b0;
          dmem_we_d  = 1'b0;
          if (!dmem_we_q) load_data_d = al_ld_data;
        end else if (wait_cnt_q == CNT_W'(MAX_WAIT - 1)) begin
          state_d     = LSU_DONE;
          dmem_req_d  = 1'b0;
          dmem_we_d   = 1'b0;
          bus_err_d   = 1'b1;
          load_data_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      LSU_DONE: begin
        state_d    = LSU_IDLE;
        wait_cnt_d = '0;
        bus_err_d  = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        misaligned_d = 1'b0;
`endif
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= LSU_IDLE;
      wait_cnt_q    <= '0;
      dmem_req_q    <= 1'b0;
      dmem_we_q     <= 1'b0;
      dmem_addr_q   <= '0;
      dmem_wdata_q  <= '0;
      dmem_be_q     <= '0;
      load_data_q   <= '0;
      bus_err_q     <= 1'b0;
      ld_size_q     <= SZ_B;
      ld_unsigned_q <= 1'b0;
      lane_q        <= 2'b00;
`ifdef LSU_MISALIGN_TRAP_EN
      misaligned_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      dmem_req_q    <= dmem_req_d;
      dmem_we_q     <= dmem_we_d;
      dmem_addr_q   <= dmem_addr_d;
      dmem_wdata_q  <= dmem_wdata_d;
      dmem_be_q     <= dmem_be_d;
      load_data_q   <= load_data_d;
      bus_err_q     <= bus_err_d;
      ld_size_q     <= ld_size_d;
      ld_unsigned_q <= ld_unsigned_d;
      lane_q        <= lane_d;
`ifdef LSU_MISALIGN_TRAP_EN
      misaligned_q  <= misaligned_d;
`endif
    end
  end

  assign stall      = rst_n & (((state_q == LSU_IDLE) & start) | (state_q == LSU_REQ));
  assign load_data  = load_data_q;
  assign bus_err    = bus_err_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign dmem_be    = dmem_be_q;

endmodule
